// File: rtl/seq_shift_add_mul_pkg.sv
// seq_mul_pkg: state encoding and counter sizing shared by the shift-add multiplier.
package seq_mul_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_shift_add_mul_if.sv
// seq_shift_add_mul_if: start/operand request and busy/done/product response of the multiplier.
interface seq_shift_add_mul_if #(parameter int WIDTH_A = 7, parameter int WIDTH_B = 7);
  logic start;
  logic [WIDTH_A-1:0] a;
  logic [WIDTH_B-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH_A+WIDTH_B-1:0] product;
  modport master(output start, a, b, input busy, done, product);
  modport slave(input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_shift_add_mul_addsub.sv
// seq_mul_addsub: W+1-bit partial-sum adder/subtractor; SEQ_MUL_SIGNED_EN sign-extends operands.
module seq_mul_addsub #(parameter int W = 7) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         en,
  input  logic         sub,
  output logic [W:0]   s
);
  logic [W:0] ex, ey;
`ifdef SEQ_MUL_SIGNED_EN
  assign ex = {x[W-1], x};
  assign ey = {y[W-1], y};
`else
  assign ex = {1'b0, x};
  assign ey = {1'b0, y};
`endif
  assign s = !en ? ex : sub ? ex - ey : ex + ey;
endmodule

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: sequential shift-add multiplier, one partial product per clock.
// SEQ_MUL_SIGNED_EN selects two's complement operands (MSB partial product subtracted).
module seq_shift_add_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH_A = 7,
  parameter int WIDTH_B = 7
) (
  input logic clk,
  input logic rst,
  seq_shift_add_mul_if.slave bus
);
  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int CW = cnt_w(WIDTH_A);
  state_t state, nxt;
  logic [PW-1:0] p;
  logic [WIDTH_B-1:0] bq;
  logic [CW-1:0] cnt;
  logic [WIDTH_B:0] sum;
  logic last, sub, accept;
  assign last = cnt == CW'(WIDTH_A - 1);
  assign accept = bus.start && state != RUN;
`ifdef SEQ_MUL_SIGNED_EN
  assign sub = last;
`else
  assign sub = 1'b0;
`endif
  seq_mul_addsub #(.W(WIDTH_B)) u_addsub (
    .x(p[PW-1:WIDTH_A]),
    .y(bq),
    .en(p[0]),
    .sub(sub),
    .s(sum)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      p <= '0;
      bq <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        p <= {{WIDTH_B{1'b0}}, bus.a};
        bq <= bus.b;
        cnt <= '0;
      end else if (state == RUN) begin
        // sum's top bit is the carry (unsigned) or the sign (signed) of the partial sum
        p <= {sum, p[WIDTH_A-1:1]};
        cnt <= cnt + 1'b1;
      end
    end
  end
  always_comb nxt = state == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  always_comb begin
    bus.busy = state == RUN;
    bus.done = state == DONE;
  end
  assign bus.product = p;
endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb_seq_shift_add_mul: directed vectors with a product scoreboard checked on every done pulse.
module tb_seq_shift_add_mul;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  logic [13:0] exp_q[$];
  seq_shift_add_mul_if #(.WIDTH_A(7), .WIDTH_B(7)) bus ();
  seq_shift_add_mul #(.WIDTH_A(7), .WIDTH_B(7)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      logic [13:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got product %0d expected no done", bus.product);
      end else begin
        e = exp_q.pop_front();
        if (bus.product !== e) begin
          errors++;
          $display("FAIL product: got %0d (0x%h) expected %0d (0x%h)", bus.product, bus.product, e, e);
        end
      end
    end
  end

  task automatic drive(input logic [6:0] av, input logic [6:0] bv);
    @(posedge clk);
    #1 bus.start = 1; bus.a = av; bus.b = bv;
    @(posedge clk);
    #1 bus.start = 0;
  endtask

  task automatic wait_done(output int busy_n);
    bit seen = 0;
    busy_n = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else if (bus.busy) busy_n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic op(input logic [6:0] av, input logic [6:0] bv, input logic [13:0] e);
    int n;
    exp_q.push_back(e);
    drive(av, bv);
    wait_done(n);
  endtask

  initial begin
    int n;
    bus.start = 0; bus.a = 0; bus.b = 0;
    repeat (2) @(posedge clk);
    #1 chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_product", 32'(bus.product), 0);
    rst = 0;
`ifdef SEQ_MUL_SIGNED_EN
    op(7'h7F, 7'h40, 14'd64);
    op(7'h40, 7'h3F, 14'h3040);
    op(7'h3F, 7'h7F, 14'h3FC1);
    op(7'h40, 7'h40, 14'h1000);
`else
    exp_q.push_back(14'd16129);
    drive(7'd127, 7'd127);
    wait_done(n);
    chk("latency_busy_cycles", 32'(n), 7);
    @(negedge clk);
    chk("idle_done_low", 32'(bus.done), 0);
    chk("idle_product_held", 32'(bus.product), 16129);
`endif
    op(7'd0, 7'd99, 14'd0);
    op(7'd1, 7'd0, 14'd0);
    op(7'd5, 7'd13, 14'd65);
    exp_q.push_back(14'd12);
    drive(7'd3, 7'd4);
    repeat (2) @(posedge clk);
    #1 bus.start = 1; bus.a = 7'd9; bus.b = 7'd9;
    @(posedge clk);
    #1 bus.start = 0;
    chk("ignored_start_busy", 32'(bus.busy), 1);
    wait_done(n);
    @(posedge clk);
    #1 bus.start = 1; bus.a = 7'd6; bus.b = 7'd7;
    exp_q.push_back(14'd42);
    @(posedge clk);
    #1 bus.a = 7'd10; bus.b = 7'd10;
    exp_q.push_back(14'd100);
    wait_done(n);
    @(posedge clk);
    #1 bus.start = 0;
    chk("b2b_busy", 32'(bus.busy), 1);
    chk("b2b_done_drop", 32'(bus.done), 0);
    wait_done(n);
    drive(7'd100, 7'd100);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1 chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_product", 32'(bus.product), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    op(7'd2, 7'd3, 14'd6);
    repeat (12) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
